data_memory_sync: RTL and testbench
===================================

// Module: data_memory_sync
// PURPOSE
//   Parametrised, single-port data memory for the single-cycle/multicycle core datapath.
//   Writes are synchronous and use byte strobes; reads are registered with 1-cycle latency.
//   After reset, an internal sequencer loads word i with value i (the data-memory power-on image).
//   The block accepts no requests until that load completes.
//   Sits between the core load/store unit and the data bus.
// PARAMETERS
//   DATA_W   32   word width in bits (multiple of 8)
//   DEPTH    32   number of words (power of 2, >= 2)
//   ADDR_W   32   byte-address width
//   (derived) BOFF = $clog2(DATA_W/8), IDX_W = $clog2(DEPTH)
// PORTS
//   clk     in   1         single clock, rising edge
//   rst_n   in   1         asynchronous, active-low reset
//   req     in   1         access request, sampled when ready=1
//   we      in   1         1 = write, 0 = read (qualified by req)
//   addr    in   ADDR_W    byte address; word index = addr[BOFF+IDX_W-1:BOFF]
//   wdata   in   DATA_W    write data
//   wstrb   in   DATA_W/8  byte write enables (bit k -> wdata[8k+7:8k])
//   ready   out  1         1 = accepting requests (RUN state)
//   rdata   out  DATA_W    read data, valid when rvalid=1, held until next read
//   rvalid  out  1         1-cycle pulse, one cycle after an accepted read
//   err     out  1         address-range error pulse (only with DMEM_ADDR_CHECK_EN, else tied 0)
// BEHAVIOUR
//   Reset (rst_n=0, async): ready=0, rvalid=0, rdata=0, err=0, FSM=INIT, init_cnt=0.
//     Array contents are not reset directly; the INIT sweep overwrites them.
//   FSM INIT: each cycle writes mem[init_cnt] = init_cnt (zero-extended), then increments init_cnt.
//     When init_cnt == DEPTH-1, the FSM enters RUN on the next edge.
//     The sweep takes exactly DEPTH cycles; ready rises on cycle DEPTH after rst_n deasserts.
//   INIT: req is ignored (no write, no rvalid). Requests are not queued.
//   RUN: accepted request = req & ready. RUN -> INIT happens only via rst_n.
//   Write: on the accepting edge, each byte k with wstrb[k]=1 is updated; other bytes keep their value.
//     A write with wstrb=0 is a no-op.
//   Read: rdata <= mem[idx] on the accepting edge; rvalid=1 for exactly the following cycle.
//   Back-to-back reads are allowed every cycle; rvalid then stays high continuously.
//   Read of a word written on the immediately preceding edge returns the new data.
//   The port is single-access (read XOR write per cycle), so same-cycle R/W cannot occur.
//   addr[BOFF-1:0] is ignored; no alignment fault is raised.
//   Address bits above BOFF+IDX_W are ignored, so indices wrap modulo DEPTH (default build).
//   Reset asserted mid-INIT or mid-read: the in-flight rvalid is dropped and the sweep restarts from 0.
// CONFIGURATION
//   Macro DMEM_ADDR_CHECK_EN.
//   Defined: an access with any addr bit >= BOFF+IDX_W set is out of range.
//     Out-of-range write: suppressed, memory unchanged.
//     Out-of-range read: rdata <= 0.
//     Either case: err pulses for 1 cycle, aligned with the cycle rvalid would occupy.
//   Undefined: no range check; indices wrap as above; err is tied to 0.
// STRUCTURE
//   Package dmem_pkg:
//     localparams DMEM_DATA_W=32, DMEM_DEPTH=32
//     typedef enum logic {DM_INIT, DM_RUN} dm_state_t
//     function byte_merge(old, new, strb)
//   Sub-module dmem_array:
//     reg array with byte-strobe write port and registered read port
//     no reset; DATA_W/DEPTH parameters
//   Top data_memory_sync owns the FSM, init counter, request qualification and range check.
// TESTING
//   1. Deassert rst_n, wait 32 cycles.
//      -> ready=1 at cycle 32; reads of addr 0x0, 0x7C return 0x0, 0x1F; rvalid exactly 1 cycle after each req.
//   2. RUN: write addr 0x10, wdata 0xAABBCCDD, wstrb 4'b0101; then read 0x10.
//      -> rdata 0x00BB00DD (init value 0x4 overwritten in byte 0).
//   3. req=1, we=0 at cycles 1..5 of INIT.
//      -> rvalid never asserts, memory unchanged; the first RUN read of 0x8 returns 0x2.
//   4. Write addr 0x20 = 0x12345678, then read addr 0x20 on the next cycle, then read 0x24.
//      -> rdata 0x12345678, then 0x9; rvalid held high for 2 cycles.
//   5. Assert rst_n low for 1 cycle at cycle 10 of INIT, and again during an outstanding read.
//      -> ready=0, rvalid=0 immediately; ready returns 32 cycles after release; word 0x3 reads 0x3.
//   6. Read addr 0x84. Without DMEM_ADDR_CHECK_EN: rdata 0x1 (wrap), err=0.
//      With DMEM_ADDR_CHECK_EN: rdata 0x0, err=1 pulse, and a write to 0x84 leaves word 1 = 0x1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the synchronous data memory.
// Holds the FSM state type, default geometry and the byte-strobe merge helper.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 32;
    localparam int DMEM_STRB_W = DMEM_DATA_W / 8;

    typedef enum logic {
        DM_INIT,
        DM_RUN
    } dm_state_t;

    // Bytes whose strobe bit is set come from new_w; all others keep old_w.
    function automatic logic [DMEM_DATA_W-1:0] byte_merge(
        input logic [DMEM_DATA_W-1:0] old_w,
        input logic [DMEM_DATA_W-1:0] new_w,
        input logic [DMEM_STRB_W-1:0] strb
    );
        logic [DMEM_DATA_W-1:0] res;
        res = old_w;
        for (int k = 0; k < DMEM_STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with a byte-strobe write port and an asynchronous read tap.
// Contents are never reset; the owner initialises them by writing every word.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < DATA_W / 8; k++) begin
                if (wstrb_i[k]) begin
                    mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Single-access port: read and write never target the same cycle, so the
    // top can register this tap and still see data written on the prior edge.
    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_memory_sync.sv
// Single-port data memory: power-on sweep loads word i with i, then serves
// byte-strobed writes and 1-cycle-latency reads. Optional range check: DMEM_ADDR_CHECK_EN.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err
);

    localparam int BOFF  = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a request is taken on a rising edge where req=1 and ready=1;
    // a taken read returns rdata with rvalid=1 for exactly the next cycle.
    dm_state_t            state_q;
    logic [IDX_W-1:0]     init_cnt_q;
    logic                 ready_q;
    logic                 rvalid_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 err_q;

    logic                 acc_d;
    logic                 rd_acc_d;
    logic                 oor_d;
    logic                 arr_we_d;
    logic [IDX_W-1:0]     arr_idx_d;
    logic [DATA_W-1:0]    arr_wdata_d;
    logic [DATA_W/8-1:0]  arr_wstrb_d;
    logic [DATA_W-1:0]    arr_rdata;
    logic                 unused_addr_bits;

`ifdef DMEM_ADDR_CHECK_EN
    assign oor_d = |(addr >> (BOFF + IDX_W));
`else
    assign oor_d = 1'b0;
`endif

    assign unused_addr_bits = ^addr;

    assign acc_d    = req & ready_q;
    assign rd_acc_d = acc_d & ~we;

    always_comb begin
        arr_we_d    = 1'b0;
        arr_idx_d   = addr[BOFF+IDX_W-1:BOFF];
        arr_wdata_d = wdata;
        arr_wstrb_d = wstrb;
        if (state_q == DM_INIT) begin
            arr_we_d    = 1'b1;
            arr_idx_d   = init_cnt_q;
            arr_wdata_d = DATA_W'(init_cnt_q);
            arr_wstrb_d = '1;
        end else begin
            arr_we_d = acc_d & we & ~oor_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we_d),
        .idx_i   (arr_idx_d),
        .wdata_i (arr_wdata_d),
        .wstrb_i (arr_wstrb_d),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DM_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                DM_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    rvalid_q   <= 1'b0;
                    err_q      <= 1'b0;
                    if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= DM_RUN;
                        ready_q <= 1'b1;
                    end
                end
                DM_RUN: begin
                    rvalid_q <= rd_acc_d;
                    err_q    <= acc_d & oor_d;
                    if (rd_acc_d) begin
                        rdata_q <= oor_d ? '0 : arr_rdata;
                    end
                end
                default: begin
                    state_q <= DM_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync: directed scenarios plus random traffic
// checked against a word-array reference model.
module tb_data_memory_sync;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int EW     = DATA_W + 1 + 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [STRB_W-1:0] wstrb = '0;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;

    data_memory_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    // clock / reset-independent cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [EW-1:0]     exp_q[$];
    int                err_due_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                model_ready = 1'b0;
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int unsigned word_of(input logic [ADDR_W-1:0] a);
        return (a / 4) % DEPTH;
    endfunction

    function automatic bit out_of_range(input logic [ADDR_W-1:0] a);
`ifdef DMEM_ADDR_CHECK_EN
        return a >= 4 * DEPTH;
`else
        return a != a;
`endif
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DATA_W'(i);
    endtask

    // driver tasks: each drives one cycle and returns 1 time unit after the edge
    task automatic do_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        bit o;
        req = 1'b1; we = 1'b0; addr = a; wdata = $urandom; wstrb = STRB_W'($urandom);
        if (model_ready) begin
            o = out_of_range(a);
            d = o ? '0 : model_mem[word_of(a)];
            exp_q.push_back({16'(cyc + 1), o, d});
        end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [STRB_W-1:0] s);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = s;
        if (model_ready) begin
            if (out_of_range(a)) begin
                err_due_q.push_back(cyc + 1);
            end else begin
                for (int k = 0; k < STRB_W; k++)
                    if (s[k]) model_mem[word_of(a)][8*k +: 8] = d[8*k +: 8];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_idle();
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_ready = 1'b0;
        exp_q.delete();
        err_due_q.delete();
        #1;
        check("rst_ready", ready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
    endtask

    // Release reset; during the sweep, issue reads of 0x8 then random traffic.
    // abort_at > 0 returns after that many cycles, still in the sweep.
    task automatic release_and_init(input int abort_at);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_init();
        for (int n = 1; n <= DEPTH; n++) begin
            if (n <= 5) begin
                req = 1'b1; we = 1'b0; addr = 32'h8;
            end else begin
                req = 1'($urandom); we = 1'($urandom);
                addr = $urandom_range(0, 255); wdata = $urandom; wstrb = STRB_W'($urandom);
            end
            @(posedge clk); #1;
            if (n == abort_at) begin
                req = 1'b0;
                return;
            end
            if (n == DEPTH - 1) check("init_ready_low", ready, 0);
            if (n == DEPTH)     check("init_ready_high", ready, 1);
        end
        req = 1'b0;
        model_ready = 1'b1;
    endtask

    task automatic random_traffic(input int count);
        int sel;
        for (int i = 0; i < count; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) do_idle();
            else if (sel < 6) do_read($urandom_range(0, 255));
            else do_write($urandom_range(0, 255), $urandom, STRB_W'($urandom));
        end
    endtask

    // monitor: pops one expectation per rvalid cycle
    initial begin
        logic [EW-1:0] e;
        bit exp_err;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 16]) < (cyc & 16'hffff)) begin
                    e = exp_q.pop_front();
                    check("missed_rvalid", 0, 1);
                end
                if (rvalid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rvalid", rvalid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", rdata, e[DATA_W-1:0]);
                        check("rd_err", err, e[DATA_W]);
                        check("rd_latency", cyc & 16'hffff, e[EW-1 -: 16]);
                    end
                end else begin
                    exp_err = 1'b0;
                    if (err_due_q.size() > 0 && err_due_q[0] == cyc) begin
                        exp_err = 1'b1;
                        void'(err_due_q.pop_front());
                    end
                    check("idle_err", err, exp_err);
                end
            end
        end
    end

    initial begin
        assert_reset();
        #20;
        release_and_init(0);

        // power-on image and reads ignored during the sweep
        do_read(32'h8);
        do_read(32'h0);
        do_read(32'h7C);
        do_idle();

        // partial-strobe write, zero-strobe write
        do_write(32'h10, 32'hAABBCCDD, 4'b0101);
        do_read(32'h10);
        do_write(32'h30, 32'hDEADBEEF, 4'b0000);
        do_read(32'h30);
        do_idle();

        // read right after write, back-to-back reads
        do_write(32'h20, 32'h12345678, 4'b1111);
        do_read(32'h20);
        do_read(32'h24);
        do_idle();

        // unaligned and above-range addresses
        do_read(32'h84);
        do_write(32'h84, 32'hCAFEF00D, 4'b1111);
        do_read(32'h04);
        do_read(32'h13);
        do_idle();

        random_traffic(300);
        do_idle();
        do_idle();

        // reset mid-sweep, then mid-read
        assert_reset();
        release_and_init(10);
        assert_reset();
        release_and_init(0);
        do_read(32'h0C);
        check("rvalid_before_rst", rvalid, 1);
        assert_reset();
        release_and_init(0);
        do_read(32'h0C);
        do_idle();

        random_traffic(200);
        repeat (3) do_idle();
        check("scoreboard_drained", exp_q.size() + err_due_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
